dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and sequencer for the single-ported data memory. It shares the memory between the CPU load/store path (port 0) and a debug/program-loader path (port 1). Each accepted request is latched and presented to the memory for exactly one access cycle. The block captures the read data and exception status, then returns a one-cycle response pulse to the winning requester. It sits between the execute stage / debug module and the data memory.

## Interface
- `ADDR_W`, default 64: address width.
- `DATA_W`, default 64: data width.
- One clock. Reset is synchronous and active-high.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_i[1:0]` in 2: per-port request.
- `we_i[1:0]` in 2: per-port store flag.
- `ld_i[1:0]` in 2: per-port load flag.
- `sel_i[1:0]` in 2x8: per-port byte-select code (`0x01`, `0x03`, `0x0F` or `0xFF`).
- `func3_i[1:0]` in 2x3: per-port load extension code.
- `addr_i[1:0]` in 2xADDR_W: per-port effective address.
- `wdata_i[1:0]` in 2xDATA_W: per-port store data.
- `ready_o` out 1: arbiter can accept a request this cycle.
- `gnt_o[1:0]` out 2: one-hot; the port accepted this cycle.
- `rvalid_o[1:0]` out 2: one-hot response pulse.
- `rdata_o` out DATA_W: load data, valid with `rvalid_o`.
- `rexc_en_o` out 1: exception flag, valid with `rvalid_o`.
- `rexc_code_o` out 4: exception code, valid with `rvalid_o`.
- `rexc_val_o` out ADDR_W: faulting address, valid with `rvalid_o`.
- `m_we` out 1: memory-side store enable.
- `m_ld` out 1: memory-side load flag.
- `m_sel` out 8: memory-side byte select.
- `m_func3` out 3: memory-side extension code.
- `m_addr` out ADDR_W: memory-side address.
- `m_wdata` out DATA_W: memory-side store data.
- `m_rdata` in DATA_W: combinational load data from memory.
- `m_exc_en` in 1: combinational exception flag from memory.
- `m_exc_code` in 4: combinational exception code from memory.
- `m_exc_val` in ADDR_W: combinational faulting address from memory.

## Operation
- FSM states: `IDLE` and `ACCESS`.
  - In `IDLE`, `ready_o`=1. If any `req_i` bit is high, accept one port, latch its fields, pulse `gnt_o` for that port, and go to `ACCESS`.
  - In `ACCESS`, `ready_o`=0 and the `m_*` outputs are driven from the latched fields. At the clock edge, capture `m_rdata` and `m_exc_*` into the response registers, set `rvalid_o` for the latched port, and return to `IDLE`.
- Outside `ACCESS`, `m_we`=0 and `m_ld`=0. The other `m_*` outputs hold their last latched values.
- Arbitration is round-robin on a one-bit `last` register.
  - If only one port requests, that port wins.
  - If both request, the port not equal to `last` wins.
  - `last` updates on every accept. Reset value is 1, so port 0 wins the first tie.
- Request sanitising at latch time:
  - `we`=1 together with `ld`=1 is latched as a store only (`ld` forced to 0).
  - A request with `we`=0 and `ld`=0 is still granted and sequenced. It produces an `rvalid_o` pulse with `rdata_o`=0 and `rexc_en_o`=0.
- Exceptions do not change sequencing. The response carries them.
- A faulting store is still driven with `m_we`=1. The memory itself suppresses the write.
- Requesters must hold `req_i` and all request fields stable until `gnt_o` is seen. Fields may change in the cycle after the grant.

## Timing
- Reset values: state=`IDLE`, `last`=1, `gnt_o`=0, `rvalid_o`=0, `rdata_o`=0, `rexc_en_o`=0, `rexc_code_o`=0, `rexc_val_o`=0, all latched `m_*` fields=0.
- `gnt_o` is combinational in the `IDLE` cycle: `gnt_o` = selected port AND `ready_o`.
- Latency: accept at edge k; memory access during cycle k..k+1; `rvalid_o` high for exactly the one cycle after edge k+1. A store commits at edge k+1.
- Throughput: one transaction per 2 cycles. The response cycle is an `IDLE` cycle and may accept the next request.
- `rvalid_o` and the response data are registered. Response data holds until the next response.
- While `rst`=1, `m_we` and `m_ld` are forced to 0 combinationally. Reset asserted during `ACCESS` therefore commits no store and produces no `rvalid_o`.

## Test plan
- Port 0 only: load, `addr`=`0x80002000`, `sel`=`0x0F`, `func3`=`2`.
  - `gnt_o`=`01` in cycle 0.
  - `m_ld`=1 in cycle 1.
  - `rvalid_o`=`01` in cycle 2 with `rdata_o`=`0xFFFFFFFFADDE2000`.
- Both ports request every cycle from reset.
  - Grants alternate 0,1,0,1 on cycles 0,2,4,6.
  - `rvalid_o` alternates `01`,`10` on cycles 2,4,6,8.
- Port 1 store of `0x1122334455667788` (`sel`=`0xFF`) to `0x80000010`, then port 0 load `0xFF` from the same address.
  - The load returns `0x1122334455667788`.
- Port 0 load, `sel`=`0x0F`, `addr`=`0x80000002`.
  - `rvalid_o`=`01` with `rexc_en_o`=1, `rexc_code_o`=4, `rexc_val_o`=`0x80000002`.
  - Next grant still occurs normally.
- Port 1 store accepted, then `rst` asserted during `ACCESS`.
  - `m_we` stays 0, memory is unchanged, no `rvalid_o`.
  - After reset, a tie grants port 0 first.
- Port 0 request with `we`=1 and `ld`=1.
  - Executed as a store: `m_ld`=0, `rdata_o`=0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter for the single-ported data memory: latches the
// winning request, drives one access cycle, and returns a registered response.
module dmem_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req_i,
    input  logic [1:0]             we_i,
    input  logic [1:0]             ld_i,
    input  logic [1:0][7:0]        sel_i,
    input  logic [1:0][2:0]        func3_i,
    input  logic [1:0][ADDR_W-1:0] addr_i,
    input  logic [1:0][DATA_W-1:0] wdata_i,
    output logic                   ready_o,
    output logic [1:0]             gnt_o,
    output logic [1:0]             rvalid_o,
    output logic [DATA_W-1:0]      rdata_o,
    output logic                   rexc_en_o,
    output logic [3:0]             rexc_code_o,
    output logic [ADDR_W-1:0]      rexc_val_o,
    output logic                   m_we,
    output logic                   m_ld,
    output logic [7:0]             m_sel,
    output logic [2:0]             m_func3,
    output logic [ADDR_W-1:0]      m_addr,
    output logic [DATA_W-1:0]      m_wdata,
    input  logic [DATA_W-1:0]      m_rdata,
    input  logic                   m_exc_en,
    input  logic [3:0]             m_exc_code,
    input  logic [ADDR_W-1:0]      m_exc_val
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic                last_q, last_d;
    logic                port_q, port_d;
    logic                we_q, we_d;
    logic                ld_q, ld_d;
    logic [7:0]          sel_q, sel_d;
    logic [2:0]          func3_q, func3_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [1:0]          rvalid_q, rvalid_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rexc_en_q, rexc_en_d;
    logic [3:0]          rexc_code_q, rexc_code_d;
    logic [ADDR_W-1:0]   rexc_val_q, rexc_val_d;
    logic                win_s;

    // Arbitration, request latching and response capture.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        port_d      = port_q;
        we_d        = we_q;
        ld_d        = ld_q;
        sel_d       = sel_q;
        func3_d     = func3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rvalid_d    = 2'b00;
        rdata_d     = rdata_q;
        rexc_en_d   = rexc_en_q;
        rexc_code_d = rexc_code_q;
        rexc_val_d  = rexc_val_q;
        ready_o     = 1'b0;
        gnt_o       = 2'b00;

        // On a tie the port that did not win last time gets the memory.
        if (req_i == 2'b11) begin
            win_s = ~last_q;
        end else begin
            win_s = req_i[1];
        end

        case (state_q)
            IDLE: begin
                ready_o = 1'b1;
                if ((req_i != 2'b00) && !rst) begin
                    gnt_o   = win_s ? 2'b10 : 2'b01;
                    state_d = ACCESS;
                    last_d  = win_s;
                    port_d  = win_s;
                    we_d    = we_i[win_s];
                    ld_d    = ld_i[win_s] & ~we_i[win_s];
                    sel_d   = sel_i[win_s];
                    func3_d = func3_i[win_s];
                    addr_d  = addr_i[win_s];
                    wdata_d = wdata_i[win_s];
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                state_d  = IDLE;
                rvalid_d = port_q ? 2'b10 : 2'b01;
                rdata_d  = ld_q ? m_rdata : {DATA_W{1'b0}};
                if (we_q || ld_q) begin
                    rexc_en_d   = m_exc_en;
                    rexc_code_d = m_exc_code;
                    rexc_val_d  = m_exc_val;
                end else begin
                    rexc_en_d   = 1'b0;
                    rexc_code_d = 4'd0;
                    rexc_val_d  = {ADDR_W{1'b0}};
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, latched request fields and registered response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            port_q      <= 1'b0;
            we_q        <= 1'b0;
            ld_q        <= 1'b0;
            sel_q       <= 8'd0;
            func3_q     <= 3'd0;
            addr_q      <= {ADDR_W{1'b0}};
            wdata_q     <= {DATA_W{1'b0}};
            rvalid_q    <= 2'b00;
            rdata_q     <= {DATA_W{1'b0}};
            rexc_en_q   <= 1'b0;
            rexc_code_q <= 4'd0;
            rexc_val_q  <= {ADDR_W{1'b0}};
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            port_q      <= port_d;
            we_q        <= we_d;
            ld_q        <= ld_d;
            sel_q       <= sel_d;
            func3_q     <= func3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            rexc_en_q   <= rexc_en_d;
            rexc_code_q <= rexc_code_d;
            rexc_val_q  <= rexc_val_d;
        end
    end

    // Reset kills an in-flight access immediately so no store can commit.
    assign m_we        = (state_q == ACCESS) && we_q && !rst;
    assign m_ld        = (state_q == ACCESS) && ld_q && !rst;
    assign m_sel       = sel_q;
    assign m_func3     = func3_q;
    assign m_addr      = addr_q;
    assign m_wdata     = wdata_q;
    assign rvalid_o    = rvalid_q;
    assign rdata_o     = rdata_q;
    assign rexc_en_o   = rexc_en_q;
    assign rexc_code_o = rexc_code_q;
    assign rexc_val_o  = rexc_val_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a byte-array memory model answers the
// memory port, a transaction-level reference predicts grants and responses.
module tb_dmem_arbiter;
    localparam int AW = 64;
    localparam int DW = 64;

    logic                clk = 1'b0;
    logic                rst;
    logic [1:0]          req_i, we_i, ld_i;
    logic [1:0][7:0]     sel_i;
    logic [1:0][2:0]     func3_i;
    logic [1:0][AW-1:0]  addr_i;
    logic [1:0][DW-1:0]  wdata_i;
    logic                ready_o;
    logic [1:0]          gnt_o, rvalid_o;
    logic [DW-1:0]       rdata_o;
    logic                rexc_en_o;
    logic [3:0]          rexc_code_o;
    logic [AW-1:0]       rexc_val_o;
    logic                m_we, m_ld;
    logic [7:0]          m_sel;
    logic [2:0]          m_func3;
    logic [AW-1:0]       m_addr;
    logic [DW-1:0]       m_wdata;
    logic [DW-1:0]       m_rdata = '0;
    logic                m_exc_en = 1'b0;
    logic [3:0]          m_exc_code = 4'd0;
    logic [AW-1:0]       m_exc_val = '0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .ld_i(ld_i),
        .sel_i(sel_i), .func3_i(func3_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .ready_o(ready_o), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .rexc_en_o(rexc_en_o), .rexc_code_o(rexc_code_o), .rexc_val_o(rexc_val_o),
        .m_we(m_we), .m_ld(m_ld), .m_sel(m_sel), .m_func3(m_func3),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
        .m_exc_en(m_exc_en), .m_exc_code(m_exc_code), .m_exc_val(m_exc_val)
    );

    typedef struct {
        bit [1:0]  port_oh;
        int        due;
        bit [63:0] rdata;
        bit        exc_en;
        bit [3:0]  code;
        bit [63:0] val;
    } resp_t;

    resp_t     exp_q[$];
    int        n_checks = 0;
    int        n_fail = 0;
    int        cyc = 0;
    bit [7:0]  env_mem[bit [63:0]];
    bit [7:0]  mdl_mem[bit [63:0]];

    // reference-model state
    bit        busy = 1'b0;
    bit        last = 1'b1;
    bit        exp_we = 1'b0, exp_ld = 1'b0;
    bit [7:0]  l_sel;
    bit [2:0]  l_f3;
    bit [63:0] l_addr, l_wd;
    bit [1:0]  acc_port = 2'b00;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Untouched memory holds 32-bit words {ADDE, low address bits}.
    function automatic bit [7:0] init_byte(bit [63:0] a);
        bit [31:0] w;
        w = {16'hADDE, a[15:2], 2'b00};
        return w[8*a[1:0] +: 8];
    endfunction

    function automatic bit [7:0] rd_byte(bit which, bit [63:0] a);
        if (which) return mdl_mem.exists(a) ? mdl_mem[a] : init_byte(a);
        return env_mem.exists(a) ? env_mem[a] : init_byte(a);
    endfunction

    function automatic void wr_byte(bit which, bit [63:0] a, bit [7:0] d);
        if (which) mdl_mem[a] = d;
        else env_mem[a] = d;
    endfunction

    function automatic int size_of(bit [7:0] sel);
        case (sel)
            8'h01:   return 1;
            8'h03:   return 2;
            8'h0F:   return 4;
            default: return 8;
        endcase
    endfunction

    // RISC-V style access: misaligned faults (4 load, 6 store), func3[2] = unsigned.
    function automatic resp_t access(bit which, bit we, bit ld, bit [7:0] sel, bit [2:0] f3,
                                     bit [63:0] addr, bit [63:0] wd, bit do_write);
        resp_t r;
        int    n;
        n = size_of(sel);
        r.port_oh = 2'b00; r.due = 0; r.rdata = 64'd0;
        r.exc_en = 1'b0; r.code = 4'd0; r.val = 64'd0;
        if (!we && !ld) return r;
        if ((addr % 64'(n)) != 64'd0) begin
            r.exc_en = 1'b1;
            r.code   = we ? 4'd6 : 4'd4;
            r.val    = addr;
            return r;
        end
        if (we) begin
            if (do_write)
                for (int i = 0; i < n; i++) wr_byte(which, addr + 64'(i), wd[8*i +: 8]);
            return r;
        end
        for (int i = 0; i < n; i++) r.rdata[8*i +: 8] = rd_byte(which, addr + 64'(i));
        if (!f3[2] && n < 8 && r.rdata[8*n-1]) r.rdata = r.rdata | (~64'd0 << (8*n));
        return r;
    endfunction

    // Memory environment: combinational answer, store committed at the edge.
    initial begin
        resp_t     r;
        bit        pend;
        bit [7:0]  p_sel;
        bit [2:0]  p_f3;
        bit [63:0] p_addr, p_wd;
        forever begin
            @(negedge clk); #3;
            r = access(1'b0, m_we, m_ld, m_sel, m_func3, m_addr, m_wdata, 1'b0);
            m_rdata = r.rdata; m_exc_en = r.exc_en; m_exc_code = r.code; m_exc_val = r.val;
            pend = m_we; p_sel = m_sel; p_f3 = m_func3; p_addr = m_addr; p_wd = m_wdata;
            @(posedge clk);
            if (pend) void'(access(1'b0, 1'b1, 1'b0, p_sel, p_f3, p_addr, p_wd, 1'b1));
        end
    end

    // Monitor: pops the scoreboard whenever a response is presented.
    initial begin
        resp_t e;
        forever begin
            @(negedge clk); #1;
            cyc++;
            if (rvalid_o != 2'b00) begin
                if (exp_q.size() == 0) begin
                    check("rvalid_unexpected", rvalid_o, 2'b00);
                end else begin
                    e = exp_q.pop_front();
                    check("rvalid_port", rvalid_o, e.port_oh);
                    check("rvalid_cycle", cyc, e.due);
                    check("rdata", rdata_o, e.rdata);
                    check("rexc_en", rexc_en_o, e.exc_en);
                    check("rexc_code", rexc_code_o, e.code);
                    check("rexc_val", rexc_val_o, e.val);
                end
            end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
                check("rvalid_missing", rvalid_o, exp_q[0].port_oh);
                void'(exp_q.pop_front());
            end
        end
    end

    // One clock of the reference model; called at a falling edge after inputs are set.
    task automatic tick();
        resp_t    r;
        bit       win;
        bit [1:0] eg;
        acc_port = 2'b00;
        #2;
        if (rst) begin
            check("mem_en_in_reset", {m_we, m_ld}, 2'b00);
            check("gnt_in_reset", gnt_o, 2'b00);
            busy = 1'b0; last = 1'b1;
            exp_q.delete();
        end else if (busy) begin
            check("ready_busy", ready_o, 1'b0);
            check("gnt_busy", gnt_o, 2'b00);
            check("m_we_m_ld", {m_we, m_ld}, {exp_we, exp_ld});
            check("m_addr", m_addr, l_addr);
            if (exp_we) void'(access(1'b1, 1'b1, 1'b0, l_sel, l_f3, l_addr, l_wd, 1'b1));
            busy = 1'b0;
        end else begin
            check("ready_idle", ready_o, 1'b1);
            check("mem_en_idle", {m_we, m_ld}, 2'b00);
            eg = 2'b00;
            if (req_i != 2'b00) begin
                if (req_i == 2'b11) win = (last == 1'b1) ? 1'b0 : 1'b1;
                else win = (req_i == 2'b10);
                eg = win ? 2'b10 : 2'b01;
                exp_we = we_i[win];
                exp_ld = ld_i[win] && !we_i[win];
                l_sel = sel_i[win]; l_f3 = func3_i[win]; l_addr = addr_i[win]; l_wd = wdata_i[win];
                r = access(1'b1, exp_we, exp_ld, l_sel, l_f3, l_addr, l_wd, 1'b0);
                r.port_oh = eg;
                r.due = cyc + 2;
                exp_q.push_back(r);
                last = win; busy = 1'b1; acc_port = eg;
            end
            check("gnt", gnt_o, eg);
        end
        @(negedge clk);
    endtask

    task automatic set_port(int p, bit we, bit ld, bit [7:0] sel, bit [2:0] f3,
                            bit [63:0] addr, bit [63:0] wd);
        req_i[p] = 1'b1; we_i[p] = we; ld_i[p] = ld; sel_i[p] = sel;
        func3_i[p] = f3; addr_i[p] = addr; wdata_i[p] = wd;
    endtask

    task automatic rand_port(int p);
        bit [2:0] f3;
        bit [7:0] sel;
        f3 = 3'($urandom_range(0, 6));
        case (f3[1:0])
            2'd0:    sel = 8'h01;
            2'd1:    sel = 8'h03;
            2'd2:    sel = 8'h0F;
            default: sel = 8'hFF;
        endcase
        set_port(p, 1'($urandom), 1'($urandom), sel, f3,
                 64'h80000000 + 64'($urandom_range(0, 47)), {$urandom, $urandom});
    endtask

    initial begin
        rst = 1'b1; req_i = 2'b00; we_i = 2'b00; ld_i = 2'b00; sel_i = '0;
        func3_i = '0; addr_i = '0; wdata_i = '0;
        @(negedge clk);
        repeat (2) tick();
        rst = 1'b0;
        check("reset_rvalid", rvalid_o, 2'b00);
        check("reset_rdata", rdata_o, 64'd0);
        check("reset_rexc", {rexc_en_o, rexc_code_o}, 5'd0);
        check("reset_rexc_val", rexc_val_o, 64'd0);
        check("reset_m_fields", {m_sel, m_func3}, 11'd0);

        // single port-0 sign-extended word load
        set_port(0, 1'b0, 1'b1, 8'h0F, 3'd2, 64'h80002000, 64'd0);
        tick(); req_i = 2'b00; tick();
        check("lw_rvalid", rvalid_o, 2'b01);
        check("lw_rdata", rdata_o, 64'hFFFFFFFFADDE2000);

        // both ports request continuously from reset
        rst = 1'b1; tick(); rst = 1'b0;
        set_port(0, 1'b0, 1'b1, 8'hFF, 3'd3, 64'h80000008, 64'd0);
        set_port(1, 1'b0, 1'b1, 8'h03, 3'd5, 64'h80000006, 64'd0);
        repeat (9) tick();
        req_i = 2'b00; repeat (2) tick();

        // store from port 1 then load back from port 0
        set_port(1, 1'b1, 1'b0, 8'hFF, 3'd3, 64'h80000010, 64'h1122334455667788);
        tick(); req_i = 2'b00; tick();
        set_port(0, 1'b0, 1'b1, 8'hFF, 3'd3, 64'h80000010, 64'd0);
        tick(); req_i = 2'b00; tick();
        check("store_load_rdata", rdata_o, 64'h1122334455667788);

        // misaligned load raises an exception but sequencing continues
        set_port(0, 1'b0, 1'b1, 8'h0F, 3'd2, 64'h80000002, 64'd0);
        tick(); req_i = 2'b00; tick();
        check("misaligned_rvalid", rvalid_o, 2'b01);
        check("misaligned_exc", {rexc_en_o, rexc_code_o}, {1'b1, 4'd4});
        check("misaligned_val", rexc_val_o, 64'h80000002);
        set_port(1, 1'b0, 1'b1, 8'h03, 3'd1, 64'h80000004, 64'd0);
        tick(); req_i = 2'b00; repeat (2) tick();

        // reset during a store's access cycle
        set_port(1, 1'b1, 1'b0, 8'hFF, 3'd3, 64'h80000020, 64'hDEADBEEFCAFEF00D);
        tick(); req_i = 2'b00; rst = 1'b1;
        tick(); rst = 1'b0; tick();
        set_port(0, 1'b0, 1'b1, 8'hFF, 3'd3, 64'h80000020, 64'd0);
        set_port(1, 1'b0, 1'b1, 8'h0F, 3'd6, 64'h80000028, 64'd0);
        tick(); req_i[0] = 1'b0; repeat (2) tick(); req_i = 2'b00; repeat (2) tick();

        // we and ld together execute as a store
        set_port(0, 1'b1, 1'b1, 8'hFF, 3'd3, 64'h80000030, 64'h0123456789ABCDEF);
        tick(); req_i = 2'b00; tick();
        check("we_ld_rdata", rdata_o, 64'd0);
        set_port(0, 1'b0, 1'b1, 8'hFF, 3'd3, 64'h80000030, 64'd0);
        tick(); req_i = 2'b00; repeat (2) tick();

        // randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            for (int p = 0; p < 2; p++) begin
                if (!req_i[p] || acc_port[p]) begin
                    if ($urandom_range(0, 3) != 0) rand_port(p);
                    else req_i[p] = 1'b0;
                end
            end
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0; req_i = 2'b00;
        repeat (4) tick();
        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
